// File: rtl/qu_common_pkg.sv
// Shared types for the rename / reservation-station slice of the queue unit.
// An RS entry index doubles as the result tag broadcast on the CDB.
package qu_common;

  localparam int RES_ST_ADDR_WIDTH = 3;
  localparam int RES_ST_OP_WIDTH   = 6;

  typedef logic [RES_ST_ADDR_WIDTH-1:0] res_st_addr_t;

  // qX_vld=1: operand X still waits on producer tag qX; qX_vld=0: vX holds the value.
  typedef struct packed {
    logic [RES_ST_OP_WIDTH-1:0] op;
    logic [31:0]                vj;
    logic [31:0]                vk;
    res_st_addr_t               qj;
    res_st_addr_t               qk;
    logic                       qj_vld;
    logic                       qk_vld;
    logic [31:0]                a;
    logic                       busy;
  } res_st_cell_t;

  // True when a pending operand is satisfied by the broadcast currently on the CDB.
  function automatic logic cdb_hit(input logic         cdb_valid,
                                   input res_st_addr_t cdb_tag,
                                   input logic         q_vld,
                                   input res_st_addr_t q);
    return cdb_valid && q_vld && (q == cdb_tag);
  endfunction

endpackage

// File: rtl/res_station_select.sv
// Lowest-index priority picker: one-hot grant plus encoded index of the winner.
module rs_select #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
        o_idx    = IDX_W'(i);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/res_station.sv
// Tomasulo reservation station: holds renamed ops, captures CDB results and
// issues ready entries; an entry stays allocated until its own tag is broadcast.
module res_station
  import qu_common::*;
#(
  parameter int RS_DEPTH = 2**RES_ST_ADDR_WIDTH,
  parameter int OP_WIDTH = RES_ST_OP_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_flush,
  input  logic                i_wr_en,
  input  res_st_addr_t        i_wr_addr,
  input  res_st_cell_t        i_wr_data,
  output logic                o_full,
  input  logic                i_cdb_valid,
  input  res_st_addr_t        i_cdb_tag,
  input  logic [31:0]         i_cdb_data,
  output logic                o_iss_valid,
  input  logic                i_iss_ready,
  output res_st_addr_t        o_iss_tag,
  output logic [OP_WIDTH-1:0] o_iss_op,
  output logic [31:0]         o_iss_vj,
  output logic [31:0]         o_iss_vk,
  output logic [31:0]         o_iss_a,
  output logic                o_err_overwrite
);

  logic [RS_DEPTH-1:0] r_busy;
  logic [RS_DEPTH-1:0] r_issued;
  logic [RS_DEPTH-1:0] r_qj_vld;
  logic [RS_DEPTH-1:0] r_qk_vld;
  logic [OP_WIDTH-1:0] r_op [RS_DEPTH];
  logic [31:0]         r_vj [RS_DEPTH];
  logic [31:0]         r_vk [RS_DEPTH];
  logic [31:0]         r_a  [RS_DEPTH];
  res_st_addr_t        r_qj [RS_DEPTH];
  res_st_addr_t        r_qk [RS_DEPTH];
  logic                r_full;
  logic                r_err;

  logic [RS_DEPTH-1:0] w_ready;
  logic [RS_DEPTH-1:0] w_gnt;
  res_st_addr_t        w_sel_idx;
  logic                w_sel_any;
  logic                w_accept;
  logic                w_clear;
  logic                w_byp_j;
  logic                w_byp_k;
  logic                w_wr_drop;
  logic [RS_DEPTH-1:0] w_wr_hit;
  logic [RS_DEPTH-1:0] w_rel;
  logic [RS_DEPTH-1:0] w_load;
  logic [RS_DEPTH-1:0] w_wake_j;
  logic [RS_DEPTH-1:0] w_wake_k;
  logic [RS_DEPTH-1:0] w_busy_nxt;
  logic [RS_DEPTH-1:0] w_issued_nxt;
  logic [RS_DEPTH-1:0] w_qj_vld_nxt;
  logic [RS_DEPTH-1:0] w_qk_vld_nxt;

  assign w_clear = rst || i_flush;
  assign w_ready = r_busy & ~r_issued & ~r_qj_vld & ~r_qk_vld;

  rs_select #(
    .N     (RS_DEPTH),
    .IDX_W (RES_ST_ADDR_WIDTH)
  ) u_select (
    .i_req (w_ready),
    .o_gnt (w_gnt),
    .o_idx (w_sel_idx),
    .o_any (w_sel_any)
  );

  // Issue handshake: a transfer happens only on a cycle with o_iss_valid && i_iss_ready.
  // o_iss_valid is not sticky; a lower-index entry waking up may replace the candidate.
  assign w_accept = w_sel_any && i_iss_ready;

  assign w_byp_j = cdb_hit(i_cdb_valid, i_cdb_tag, i_wr_data.qj_vld, i_wr_data.qj);
  assign w_byp_k = cdb_hit(i_cdb_valid, i_cdb_tag, i_wr_data.qk_vld, i_wr_data.qk);

  // A release in the same cycle frees the entry, so a write to it is accepted.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_wr_hit[i] = i_wr_en && (i_wr_addr == res_st_addr_t'(i));
      w_rel[i]    = i_cdb_valid && (i_cdb_tag == res_st_addr_t'(i)) && r_busy[i];
      w_load[i]   = w_wr_hit[i] && (!r_busy[i] || w_rel[i]);
      w_wake_j[i] = r_busy[i] && cdb_hit(i_cdb_valid, i_cdb_tag, r_qj_vld[i], r_qj[i]);
      w_wake_k[i] = r_busy[i] && cdb_hit(i_cdb_valid, i_cdb_tag, r_qk_vld[i], r_qk[i]);
    end
  end

  assign w_wr_drop = |(w_wr_hit & ~w_load);

  always_comb begin
    w_busy_nxt   = r_busy;
    w_issued_nxt = r_issued;
    w_qj_vld_nxt = r_qj_vld;
    w_qk_vld_nxt = r_qk_vld;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (w_load[i]) begin
        w_busy_nxt[i]   = 1'b1;
        w_issued_nxt[i] = 1'b0;
        w_qj_vld_nxt[i] = i_wr_data.qj_vld && !w_byp_j;
        w_qk_vld_nxt[i] = i_wr_data.qk_vld && !w_byp_k;
      end else begin
        if (w_rel[i]) begin
          w_busy_nxt[i]   = 1'b0;
          w_issued_nxt[i] = 1'b0;
        end else if (w_accept && w_gnt[i]) begin
          w_issued_nxt[i] = 1'b1;
        end
        if (w_wake_j[i]) w_qj_vld_nxt[i] = 1'b0;
        if (w_wake_k[i]) w_qk_vld_nxt[i] = 1'b0;
      end
    end
    if (w_clear) begin
      w_busy_nxt   = '0;
      w_issued_nxt = '0;
      w_qj_vld_nxt = '0;
      w_qk_vld_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    r_busy   <= w_busy_nxt;
    r_issued <= w_issued_nxt;
    r_qj_vld <= w_qj_vld_nxt;
    r_qk_vld <= w_qk_vld_nxt;
    r_full   <= &w_busy_nxt;
    r_err    <= !w_clear && w_wr_drop;
  end

  // Payload fields need no reset: they are only observed through a busy, ready entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (w_load[i]) begin
        r_op[i] <= OP_WIDTH'(i_wr_data.op);
        r_vj[i] <= w_byp_j ? i_cdb_data : i_wr_data.vj;
        r_vk[i] <= w_byp_k ? i_cdb_data : i_wr_data.vk;
        r_qj[i] <= i_wr_data.qj;
        r_qk[i] <= i_wr_data.qk;
        r_a[i]  <= i_wr_data.a;
      end else begin
        if (w_wake_j[i]) r_vj[i] <= i_cdb_data;
        if (w_wake_k[i]) r_vk[i] <= i_cdb_data;
      end
    end
  end

  assign o_full          = r_full;
  assign o_err_overwrite = r_err;
  assign o_iss_valid     = w_sel_any;
  assign o_iss_tag       = w_sel_any ? w_sel_idx : '0;
  assign o_iss_op        = w_sel_any ? r_op[w_sel_idx] : '0;
  assign o_iss_vj        = w_sel_any ? r_vj[w_sel_idx] : '0;
  assign o_iss_vk        = w_sel_any ? r_vk[w_sel_idx] : '0;
  assign o_iss_a         = w_sel_any ? r_a[w_sel_idx]  : '0;

endmodule
